// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and parameter checks for counter blocks (COUNTER_SATURATE_EN aware)
package counter_pkg;

    // Direction encoding on up_dn
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // True when MODULUS fits a WIDTH-bit register and gives at least two states
    function automatic bit modulus_is_legal(input int unsigned width, input longint unsigned modulus);
        if (width == 0 || width > 63) begin
            return 1'b0;
        end
        return (modulus >= 64'd2) && (modulus <= (64'd1 << width));
    endfunction

endpackage

// File: rtl/counter_next_val.sv
// rtl/counter_next_val.sv - next-state, wrap and terminal-count logic (COUNTER_SATURATE_EN selects saturation)
module counter_next_val
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic [WIDTH-1:0] count,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap_next,
    output logic             tc
);

    // Top of the count range; the extended modulus lets load clamping work when MODULUS == 2**WIDTH
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

    logic             at_max;
    logic             at_zero;
    logic             load_too_big;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] count_dec;

    assign at_max       = (count == MAX_VAL);
    assign at_zero      = (count == '0);
    assign load_too_big = ({1'b0, load_val} >= MOD_EXT);
    assign load_clamped = load_too_big ? MAX_VAL : load_val;
    assign count_inc    = count + WIDTH'(1);
    assign count_dec    = count - WIDTH'(1);

    // Combinational so a cascaded stage sees the carry in the same cycle; load does not mask it
    assign tc = en & ((up_dn == DIR_UP) ? at_max : at_zero);

    // Priority: load, then enabled count, otherwise hold
    always_comb begin
        next_count = count;
        wrap_next  = 1'b0;
        if (load) begin
            next_count = load_clamped;
        end else if (en) begin
            if (up_dn == DIR_UP) begin
                if (at_max) begin
`ifdef COUNTER_SATURATE_EN
                    next_count = MAX_VAL;
`else
                    next_count = '0;
                    wrap_next  = 1'b1;
`endif
                end else begin
                    next_count = count_inc;
                end
            end else begin
                if (at_zero) begin
`ifdef COUNTER_SATURATE_EN
                    next_count = '0;
`else
                    next_count = MAX_VAL;
                    wrap_next  = 1'b1;
`endif
                end else begin
                    next_count = count_dec;
                end
            end
        end
    end

endmodule

// File: rtl/syn_updown_counter_mod.sv
// rtl/syn_updown_counter_mod.sv - modulo up/down counter with load, tc and wrap pulse (COUNTER_SATURATE_EN selects saturation)
module syn_updown_counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    // Reject parameter sets whose range cannot be represented
    generate
        if (!modulus_is_legal(WIDTH, longint'(MODULUS))) begin : g_bad_modulus
            $error("syn_updown_counter_mod: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] next_count;
    logic             wrap_next;

    counter_next_val #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next_val (
        .count      (count),
        .en         (en),
        .up_dn      (up_dn),
        .load       (load),
        .load_val   (load_val),
        .next_count (next_count),
        .wrap_next  (wrap_next),
        .tc         (tc)
    );

    // Count and wrap registers; wrap is a one-cycle echo of the wrap decision
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= next_count;
            wrap  <= wrap_next;
        end
    end

endmodule

// File: tb/tb_syn_updown_counter_mod.sv
// tb/tb_syn_updown_counter_mod.sv - self-checking bench for syn_updown_counter_mod (COUNTER_SATURATE_EN aware)
module tb_syn_updown_counter_mod;

    localparam int WIDTH   = 4;
    localparam int MODULUS = 10;
`ifdef COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    syn_updown_counter_mod #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic             en;
        logic             up_dn;
        logic             load;
        logic [WIDTH-1:0] load_val;
        logic             exp_tc;
        logic [WIDTH-1:0] exp_count;
        logic             exp_wrap;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] count;
        logic             wrap;
        string            name;
    } sb_t;

    sb_t sb[$];
    int  tests = 0;
    int  fails = 0;
    int  m_count = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Called at a falling edge: drive, check tc, queue expected, let one rising edge pass, compare
    task automatic apply(input logic e, input logic u, input logic l, input logic [WIDTH-1:0] lv,
                         input logic etc, input logic [WIDTH-1:0] ec, input logic ew, input string nm);
        sb_t got;
        en = e; up_dn = u; load = l; load_val = lv;
        #1;
        check({nm, ".tc"}, 32'(tc), 32'(etc));
        sb.push_back('{count: ec, wrap: ew, name: nm});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({nm, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            check({got.name, ".count"}, 32'(count), 32'(got.count));
            check({got.name, ".wrap"}, 32'(wrap), 32'(got.wrap));
        end
        @(negedge clk);
    endtask

    // Reference behaviour derived from the counter description, used for longer sequences
    task automatic step(input logic e, input logic u, input logic l, input int lv, input string nm);
        int lim;
        int n;
        logic w;
        logic t;
        lim = MODULUS - 1;
        t = e && (u ? (m_count == lim) : (m_count == 0));
        n = m_count;
        w = 1'b0;
        if (l) begin
            n = (lv >= MODULUS) ? lim : lv;
        end else if (e) begin
            if (u) begin
                if (m_count == lim) begin
                    n = SAT ? lim : 0;
                    w = !SAT;
                end else begin
                    n = m_count + 1;
                end
            end else begin
                if (m_count == 0) begin
                    n = SAT ? 0 : lim;
                    w = !SAT;
                end else begin
                    n = m_count - 1;
                end
            end
        end
        apply(e, u, l, WIDTH'(lv), t, WIDTH'(n), w, nm);
        m_count = n;
    endtask

    vec_t vecs[$];

    initial begin
        reset = 1'b0; en = 1'b1; up_dn = 1'b1; load = 1'b0; load_val = '0;

        // Reset held for 200 ns with en=1: nothing may move
        repeat (10) begin
            @(negedge clk);
            check("reset.count", 32'(count), 32'd0);
            check("reset.wrap", 32'(wrap), 32'd0);
        end
        reset = 1'b1;

`ifndef COUNTER_SATURATE_EN
        //          en    up    load  lv     tc    count  wrap
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd2, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd3, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 4'd13, 1'b0, 4'd9, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 4'd0, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 4'd9, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd8, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd4,  1'b0, 4'd4, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd4, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 4'd9,  1'b0, 4'd9, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 4'd15, 1'b1, 4'd9, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 4'd0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 4'd9, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd9, 1'b0});
        foreach (vecs[i]) begin
            apply(vecs[i].en, vecs[i].up_dn, vecs[i].load, vecs[i].load_val,
                  vecs[i].exp_tc, vecs[i].exp_count, vecs[i].exp_wrap, $sformatf("vec%0d", i));
            m_count = int'(vecs[i].exp_count);
        end
`else
        step(1'b1, 1'b1, 1'b0, 0, "post_reset1");
        step(1'b1, 1'b1, 1'b0, 0, "post_reset2");
        step(1'b1, 1'b1, 1'b0, 0, "post_reset3");
`endif

        // Full up pass from 0 through the top of the range and around
        step(1'b0, 1'b1, 1'b1, 0, "up.load0");
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 0, $sformatf("up%0d", i));

        // Down from 2 across zero
        step(1'b1, 1'b1, 1'b1, 2, "dn.load2");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 0, $sformatf("dn%0d", i));

        // Random mix of loads, directions and enables
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 5) == 0),
                 int'($urandom_range(0, 15)), $sformatf("rnd%0d", i));
        end

        // Hold at 6 for five cycles, then an asynchronous reset between edges
        step(1'b0, 1'b1, 1'b1, 6, "hold.load6");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 0, $sformatf("hold%0d", i));
        @(posedge clk);
        #4;
        check("async.before", 32'(count), 32'd6);
        reset = 1'b0;
        #1;
        check("async.count", 32'(count), 32'd0);
        check("async.wrap", 32'(wrap), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        m_count = 0;
        step(1'b1, 1'b1, 1'b0, 0, "async.resume");

`ifdef COUNTER_SATURATE_EN
        // Saturation at the top: 8,9,9,9,9 with no wrap pulse
        step(1'b0, 1'b1, 1'b1, 7, "sat.load7");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 0, $sformatf("sat%0d", i));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0, $sformatf("satdn%0d", i));
`endif

        check("sb.drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
